// File: rtl/mem_line_responder.sv
// Single-port line store answering instruction- and data-cache line requests after a fixed latency.
// Optional MEM_RESP_RR_ARB_EN: round-robin tie-break between ic and dc (default: dc wins ties).
module mem_line_responder #(
  parameter int LATENCY        = 4,
  parameter int LINE_ADDR_BITS = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ic_req_in,
  input  logic         ic_we_in,
  input  logic [19:0]  ic_addr_in,
  input  logic [127:0] ic_data_in,
  output logic         ic_ready_out,
  output logic [127:0] ic_data_out,
  input  logic         dc_req_in,
  input  logic         dc_we_in,
  input  logic [19:0]  dc_addr_in,
  input  logic [127:0] dc_data_in,
  output logic         dc_ready_out,
  output logic [127:0] dc_data_out
);

  localparam int DATA_W = 128;
  localparam int DEPTH  = 1 << LINE_ADDR_BITS;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [3:0]                cnt_q, cnt_d;
  logic                      gnt_dc_q, gnt_dc_d;
  logic                      we_q, we_d;
  logic [LINE_ADDR_BITS-1:0] idx_q, idx_d;
  logic [DATA_W-1:0]         wdata_q, wdata_d;
  logic [DATA_W-1:0]         rdata_q;
  logic [DATA_W-1:0]         mem [DEPTH];

  logic gnt_req;
  logic pick_dc;
  logic rd_cap;
  logic mem_wr;
  logic addr_unused;

  // Word-offset and aliased high address bits carry no meaning for a line store.
  assign addr_unused = ^{ic_addr_in[1:0], dc_addr_in[1:0],
                         ic_addr_in[19:LINE_ADDR_BITS+2], dc_addr_in[19:LINE_ADDR_BITS+2]};

  assign gnt_req = gnt_dc_q ? dc_req_in : ic_req_in;

`ifdef MEM_RESP_RR_ARB_EN
  logic last_dc_q, last_dc_d;

  always_comb begin
    pick_dc = dc_req_in;
    if (ic_req_in && dc_req_in) begin
      pick_dc = ~last_dc_q;
    end
  end

  always_comb begin
    last_dc_d = last_dc_q;
    if (state_q == IDLE && (ic_req_in || dc_req_in)) begin
      last_dc_d = pick_dc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_dc_q <= 1'b0;
    end else begin
      last_dc_q <= last_dc_d;
    end
  end
`else
  always_comb begin
    pick_dc = dc_req_in;
  end
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gnt_dc_d = gnt_dc_q;
    we_d     = we_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    rd_cap   = 1'b0;
    mem_wr   = 1'b0;
    case (state_q)
      IDLE: begin
        if (ic_req_in || dc_req_in) begin
          gnt_dc_d = pick_dc;
          we_d     = pick_dc ? dc_we_in : ic_we_in;
          idx_d    = pick_dc ? dc_addr_in[LINE_ADDR_BITS+1:2] : ic_addr_in[LINE_ADDR_BITS+1:2];
          wdata_d  = pick_dc ? dc_data_in : ic_data_in;
          cnt_d    = LAT_M1;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        // A dropped request abandons the transfer before anything is committed.
        if (!gnt_req) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          rd_cap  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        mem_wr  = we_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control state: reset applies here only.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Transfer payload registers carry no reset; outputs are gated by state instead.
  always_ff @(posedge clk) begin
    gnt_dc_q <= gnt_dc_d;
    we_q     <= we_d;
    idx_q    <= idx_d;
    wdata_q  <= wdata_d;
    if (rd_cap) begin
      rdata_q <= mem[idx_q];
    end
  end

  // Storage survives reset; a reset at the RESP-ending edge suppresses the commit.
  always_ff @(posedge clk) begin
    if (mem_wr && !reset) begin
      mem[idx_q] <= wdata_q;
    end
  end

  always_comb begin
    ic_ready_out = (state_q == RESP) && !gnt_dc_q;
    dc_ready_out = (state_q == RESP) && gnt_dc_q;
    ic_data_out  = (ic_ready_out && !we_q) ? rdata_q : '0;
    dc_data_out  = (dc_ready_out && !we_q) ? rdata_q : '0;
  end

endmodule

// File: tb/tb_mem_line_responder.sv
// Scoreboard bench for mem_line_responder: stimulus queues expected responses, monitors pop and compare.
module tb_mem_line_responder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Instance 0: default LATENCY=4
  logic         ic_req0, ic_we0, dc_req0, dc_we0;
  logic [19:0]  ic_addr0, dc_addr0;
  logic [127:0] ic_wd0, dc_wd0;
  logic         ic_rdy0, dc_rdy0;
  logic [127:0] ic_rd0, dc_rd0;

  // Instance 1: LATENCY=1, ic port only
  logic         ic_req1, ic_we1, dc_req1, dc_we1;
  logic [19:0]  ic_addr1, dc_addr1;
  logic [127:0] ic_wd1, dc_wd1;
  logic         ic_rdy1, dc_rdy1;
  logic [127:0] ic_rd1, dc_rd1;

  mem_line_responder u_dut (
    .clk(clk), .reset(reset),
    .ic_req_in(ic_req0), .ic_we_in(ic_we0), .ic_addr_in(ic_addr0), .ic_data_in(ic_wd0),
    .ic_ready_out(ic_rdy0), .ic_data_out(ic_rd0),
    .dc_req_in(dc_req0), .dc_we_in(dc_we0), .dc_addr_in(dc_addr0), .dc_data_in(dc_wd0),
    .dc_ready_out(dc_rdy0), .dc_data_out(dc_rd0)
  );

  mem_line_responder #(.LATENCY(1)) u_dut_lat1 (
    .clk(clk), .reset(reset),
    .ic_req_in(ic_req1), .ic_we_in(ic_we1), .ic_addr_in(ic_addr1), .ic_data_in(ic_wd1),
    .ic_ready_out(ic_rdy1), .ic_data_out(ic_rd1),
    .dc_req_in(dc_req1), .dc_we_in(dc_we1), .dc_addr_in(dc_addr1), .dc_data_in(dc_wd1),
    .dc_ready_out(dc_rdy1), .dc_data_out(dc_rd1)
  );

  typedef struct {
    bit           port;   // 0 = ic, 1 = dc
    logic [127:0] data;
    int           cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  localparam logic [127:0] D1 = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] D2 = 128'hDEADBEEF_00000001_CAFEF00D_12345678;
  localparam logic [127:0] D3 = 128'hA5A5A5A5_5A5A5A5A_FFFF0000_0000FFFF;
  localparam logic [127:0] D4 = 128'h11112222_33334444_55556666_77778888;
  localparam logic [127:0] D5 = 128'h99990000_AAAA1111_BBBB2222_CCCC3333;
  localparam logic [127:0] D6 = 128'h0F0F0F0F_F0F0F0F0_01020304_05060708;
  localparam logic [127:0] D7 = 128'hFEDCBA98_76543210_FEDCBA98_76543210;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon(input int inst, input logic ic_rdy, input logic dc_rdy,
                     input logic [127:0] ic_d, input logic [127:0] dc_d);
    exp_t e;
    if (ic_rdy || dc_rdy) begin
      chk($sformatf("one_ready_inst%0d", inst), 128'(ic_rdy & dc_rdy), 128'd0);
      if ((inst == 0 && q0.size() == 0) || (inst == 1 && q1.size() == 0)) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready inst%0d: got ic=%0b dc=%0b expected none (cycle %0d)",
                 inst, ic_rdy, dc_rdy, cyc);
      end else begin
        e = (inst == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("port_inst%0d", inst), 128'(dc_rdy), 128'(e.port));
        chk($sformatf("data_inst%0d", inst), e.port ? dc_d : ic_d, e.data);
        chk($sformatf("cycle_inst%0d", inst), 128'(cyc), 128'(e.cyc));
      end
    end
    if (!ic_rdy) chk($sformatf("ic_data_idle_inst%0d", inst), ic_d, 128'd0);
    if (!dc_rdy) chk($sformatf("dc_data_idle_inst%0d", inst), dc_d, 128'd0);
  endtask

  always @(negedge clk) begin
    mon(0, ic_rdy0, dc_rdy0, ic_rd0, dc_rd0);
    mon(1, ic_rdy1, dc_rdy1, ic_rd1, dc_rd1);
  end

  function automatic logic rdy(input int inst, input bit port);
    if (inst == 1) return port ? dc_rdy1 : ic_rdy1;
    return port ? dc_rdy0 : ic_rdy0;
  endfunction

  // Waits for a ready pulse, then returns #1 after the edge that ends RESP.
  task automatic wait_ready(input int inst, input bit port);
    bit got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rdy(inst, port)) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL timeout inst%0d port%0d: got no ready expected ready within 40 cycles", inst, port);
    end
    @(posedge clk);
    #1;
  endtask

  // Call #1 after a rising edge with the DUT idle; returns #1 after a rising edge.
  task automatic do_req(input int inst, input bit port, input bit we, input logic [19:0] addr,
                        input logic [127:0] wdata, input logic [127:0] expd);
    exp_t e;
    e.port = port;
    e.data = expd;
    e.cyc  = cyc + 1 + ((inst == 1) ? 1 : 4);
    if (inst == 1) begin
      q1.push_back(e);
      ic_req1 = 1'b1; ic_we1 = we; ic_addr1 = addr; ic_wd1 = wdata;
    end else begin
      q0.push_back(e);
      if (port) begin
        dc_req0 = 1'b1; dc_we0 = we; dc_addr0 = addr; dc_wd0 = wdata;
      end else begin
        ic_req0 = 1'b1; ic_we0 = we; ic_addr0 = addr; ic_wd0 = wdata;
      end
    end
    wait_ready(inst, port);
    if (inst == 1) begin
      ic_req1 = 1'b0; ic_we1 = 1'b0;
    end else if (port) begin
      dc_req0 = 1'b0; dc_we0 = 1'b0;
    end else begin
      ic_req0 = 1'b0; ic_we0 = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Both ports request in the same cycle and hold; expectation order is dc then ic.
  task automatic tie(input logic [19:0] dc_a, input logic [127:0] dc_e,
                     input logic [19:0] ic_a, input logic [127:0] ic_e);
    exp_t e;
    e.port = 1'b1; e.data = dc_e; e.cyc = cyc + 5;
    q0.push_back(e);
    e.port = 1'b0; e.data = ic_e; e.cyc = cyc + 11;
    q0.push_back(e);
    dc_req0 = 1'b1; dc_we0 = 1'b0; dc_addr0 = dc_a;
    ic_req0 = 1'b1; ic_we0 = 1'b0; ic_addr0 = ic_a;
    wait_ready(0, 1'b1);
    dc_req0 = 1'b0;
    wait_ready(0, 1'b0);
    ic_req0 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000 time units");
    $fatal(1, "global timeout");
  end

  initial begin
    int c;
    reset = 1'b1;
    {ic_req0, ic_we0, dc_req0, dc_we0} = '0;
    {ic_req1, ic_we1, dc_req1, dc_we1} = '0;
    ic_addr0 = '0; dc_addr0 = '0; ic_wd0 = '0; dc_wd0 = '0;
    ic_addr1 = '0; dc_addr1 = '0; ic_wd1 = '0; dc_wd1 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ic_ready", 128'(ic_rdy0), 128'd0);
    chk("reset_dc_ready", 128'(dc_rdy0), 128'd0);
    reset = 1'b0;

    // Write on dc, read back on ic
    do_req(0, 1'b1, 1'b1, 20'h00010, D1, 128'd0);
    do_req(0, 1'b0, 1'b0, 20'h00010, '0, D1);
    do_req(0, 1'b1, 1'b1, 20'h00020, D2, 128'd0);
    do_req(0, 1'b0, 1'b0, 20'h00020, '0, D2);
    // 0x01010 aliases line 4, same as 0x00010
    do_req(0, 1'b0, 1'b1, 20'h01010, D3, 128'd0);
    do_req(0, 1'b1, 1'b0, 20'h00010, '0, D3);
    do_req(0, 1'b1, 1'b0, 20'h00013, '0, D3);

    // Abort: dc write to 0x00020 dropped after two BUSY cycles
    dc_req0 = 1'b1; dc_we0 = 1'b1; dc_addr0 = 20'h00020; dc_wd0 = D4;
    repeat (3) @(posedge clk);
    #1;
    dc_req0 = 1'b0; dc_we0 = 1'b0;
    @(posedge clk);
    #1;
    do_req(0, 1'b1, 1'b0, 20'h00020, '0, D2);

    // Reset mid-BUSY on a write to 0x00010
    dc_req0 = 1'b1; dc_we0 = 1'b1; dc_addr0 = 20'h00010; dc_wd0 = D5;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1; dc_req0 = 1'b0; dc_we0 = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid_dc_ready", 128'(dc_rdy0), 128'd0);
    chk("rst_mid_dc_data", dc_rd0, 128'd0);
    reset = 1'b0;
    c = cyc;
    do_req(0, 1'b1, 1'b0, 20'h00010, '0, D3);
    chk("rst_release_latency", 128'(cyc), 128'(c + 6));

    // Simultaneous requests after reset, then a repeat
    do_reset();
    tie(20'h00020, D2, 20'h00010, D3);
    tie(20'h00010, D3, 20'h00020, D2);
    do_req(0, 1'b1, 1'b1, 20'h00030, D6, 128'd0);
    do_req(0, 1'b0, 1'b0, 20'h00030, '0, D6);

    // LATENCY=1 instance
    do_req(1, 1'b0, 1'b1, 20'h00040, D7, 128'd0);
    do_req(1, 1'b0, 1'b0, 20'h00040, '0, D7);

    repeat (5) @(posedge clk);
    #1;
    chk("q0_drained", 128'(q0.size()), 128'd0);
    chk("q1_drained", 128'(q1.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
